// File: rtl/mem_test_loader.sv
// mem_test_loader: test-mode master that bulk-loads a program image into the 256x16
// data/instruction memory before the multicycle core runs.
//
// Words from an upstream valid/ready stream are written to consecutive addresses
// starting at a programmable base (wrapping mod 2^ADDR_W). While a load is active
// Tbornot hands the memory's test port to this block; it is released after done.
// All outputs are registered; the memory writes on the falling edge, so Addr_tb,
// Data_tb and WE_tb are stable for half a cycle before the write strobe.
//
// Optional feature (macro MEM_TEST_LOADER_VERIFY_EN): after the load, read every
// written word back through MemOut and compare a 16-bit modular sum of the read data
// against the sum of the streamed words; a difference sets error.
//
// Ports:
//   clk        system clock (also drives the memory's clk_n pin)
//   rst        synchronous active-high reset
//   start      one-cycle pulse, begins a load when idle
//   base_addr  first word address, latched on start
//   length     word count 0..2^ADDR_W, latched on start; larger values flag error
//   in_data    stream word
//   in_valid   stream word valid
//   in_ready   loader accepts a word this cycle
//   MemOut     memory asynchronous read data (used only by the verify pass)
//   Tbornot    memory mode select, 1 = test port owns the memory
//   Addr_tb    test-mode address
//   Data_tb    test-mode write data
//   WE_tb      test-mode write enable
//   busy       high outside IDLE
//   done       one-cycle completion pulse
//   error      sticky error, cleared by the next accepted start
module mem_test_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] MemOut,
    output logic              Tbornot,
    output logic [ADDR_W-1:0] Addr_tb,
    output logic [DATA_W-1:0] Data_tb,
    output logic              WE_tb,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] MaxLen = CntW'(1) << ADDR_W;

`ifdef MEM_TEST_LOADER_VERIFY_EN
    typedef enum logic [2:0] {StIdle, StLoad, StFlush, StDone, StVerify} state_e;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;
`endif

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CntW-1:0]     len_q, len_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                we_q, we_d;
    logic                tb_q, tb_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CntW-1:0]     cnt_inc;
    logic                accept;

`ifdef MEM_TEST_LOADER_VERIFY_EN
    logic [DATA_W-1:0]   sum_in_q, sum_in_d;
    logic [DATA_W-1:0]   sum_rd_q, sum_rd_d;
    logic [DATA_W-1:0]   sum_rd_next;
`else
    // Read data only matters to the verify pass.
    logic                unused_memout;
    assign unused_memout = ^MemOut;
`endif

    assign cnt_inc = cnt_q + CntW'(1);
    assign accept  = in_valid && ready_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        tb_d    = tb_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef MEM_TEST_LOADER_VERIFY_EN
        sum_in_d    = sum_in_q;
        sum_rd_d    = sum_rd_q;
        sum_rd_next = sum_rd_q + MemOut;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d = base_addr;
                    len_d  = length;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    tb_d   = 1'b1;
                    busy_d = 1'b1;
`ifdef MEM_TEST_LOADER_VERIFY_EN
                    sum_in_d = '0;
`endif
                    if (length == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else if (length > MaxLen) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StLoad;
                        ready_d = 1'b1;
                    end
                end
            end

            StLoad: begin
                ready_d = ready_q;
                if (accept) begin
                    addr_d = base_q + cnt_q[ADDR_W-1:0];
                    data_d = in_data;
                    we_d   = 1'b1;
                    cnt_d  = cnt_inc;
`ifdef MEM_TEST_LOADER_VERIFY_EN
                    sum_in_d = sum_in_q + in_data;
`endif
                    // in_ready drops on the same edge that takes the final word.
                    if (cnt_inc == len_q) begin
                        ready_d = 1'b0;
                        state_d = StFlush;
                    end
                end
            end

            // The final write's WE_tb is high during this cycle.
            StFlush: begin
`ifdef MEM_TEST_LOADER_VERIFY_EN
                state_d  = StVerify;
                addr_d   = base_q;
                cnt_d    = '0;
                sum_rd_d = '0;
`else
                state_d = StDone;
                done_d  = 1'b1;
`endif
            end

`ifdef MEM_TEST_LOADER_VERIFY_EN
            // MemOut reflects the current Addr_tb; fold it in at the end of each cycle.
            StVerify: begin
                sum_rd_d = sum_rd_next;
                cnt_d    = cnt_inc;
                if (cnt_inc == len_q) begin
                    if (sum_rd_next != sum_in_q) begin
                        err_d = 1'b1;
                    end
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
`endif

            StDone: begin
                state_d = StIdle;
                tb_d    = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
                tb_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            tb_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_TEST_LOADER_VERIFY_EN
            sum_in_q <= '0;
            sum_rd_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            tb_q    <= tb_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MEM_TEST_LOADER_VERIFY_EN
            sum_in_q <= sum_in_d;
            sum_rd_q <= sum_rd_d;
`endif
        end
    end

    assign in_ready = ready_q;
    assign Tbornot  = tb_q;
    assign Addr_tb  = addr_q;
    assign Data_tb  = data_q;
    assign WE_tb    = we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = err_q;

endmodule

// File: doc/mem_test_loader.md
Name: mem_test_loader

Overview:
- Test-mode master for the 256x16 data/instruction memory. Drives the memory's test-mode port (mode select, address, data, write enable) to bulk-load a program image before the multicycle RISC core runs.
- Takes 16-bit words from an upstream valid/ready stream (UART receiver, ROM image, or bench) and writes them to consecutive addresses from a programmable base.
- On completion it returns memory control to the processor.

Parameters:
- ADDR_W, 8, memory address width (256 words)
- DATA_W, 16, memory word width

Ports:
- clk  input  1  system clock; the same net drives the memory's clk_n pin
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins a load when idle
- base_addr  input  8  first word address, latched on start
- length  input  9  word count, 0..256, latched on start
- in_data  input  16  stream word
- in_valid  input  1  stream word valid
- in_ready  output  1  loader accepts word this cycle
- MemOut  input  16  memory read data (asynchronous read)
- Tbornot  output  1  memory mode select; 1 = test port owns memory
- Addr_tb  output  8  test-mode address
- Data_tb  output  16  test-mode write data
- WE_tb  output  1  test-mode write enable
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion pulse
- error  output  1  sticky error; cleared on the next accepted start

Behaviour:
- Clock and reset:
  - Single clock. All outputs are registered on the rising edge of clk.
  - The memory writes on the falling edge, half a cycle after these outputs settle.
  - rst is synchronous and active-high. It is the only reset.
- Reset values:
  - Tbornot, WE_tb, in_ready, busy, done and error are 0.
  - Addr_tb is 0x00 and Data_tb is 0x0000.
  - State is IDLE.
  - A reset during any state aborts at that edge: Tbornot and WE_tb fall and no further writes occur.
- FSM states: IDLE, LOAD, FLUSH, DONE (plus VERIFY when the optional feature is enabled).
- IDLE:
  - On start, latch base_addr and length, clear error and the word counter, and set Tbornot=1.
  - length == 0: go to DONE and perform no writes.
  - length > 256: set error=1, go to DONE, perform no writes.
  - Otherwise go to LOAD.
  - A start pulse in any other state is ignored.
- LOAD:
  - in_ready = 1 while count < length.
  - Acceptance means in_valid && in_ready at a rising edge.
  - A word accepted at edge t makes these values valid for the whole cycle after t:
    - Addr_tb = (base + count) mod 256; the address wraps from 0xFF to 0x00.
    - Data_tb = in_data.
    - WE_tb = 1.
    - Then count increments.
  - Back-to-back acceptance sustains one write per cycle.
  - In a cycle with no acceptance, WE_tb = 0 and Addr_tb/Data_tb hold.
  - When the final word is accepted, in_ready drops at the same edge and the FSM goes to FLUSH.
- FLUSH:
  - Exactly one cycle. The last write's WE_tb is high here with Tbornot still 1.
  - Goes to VERIFY if that feature is compiled in, otherwise to DONE.
- DONE:
  - Exactly one cycle: done = 1, WE_tb = 0, Tbornot still 1.
  - Then IDLE, where Tbornot = 0 and busy = 0.
- Invariants:
  - WE_tb is never 1 while Tbornot is 0.
  - Tbornot rises on the edge after start and falls on the edge after done.
- Word count: exactly `length` writes per load, including length == 256 (every address written once).

Optional Feature:
- Macro: MEM_TEST_LOADER_VERIFY_EN.
- Enabled:
  - During LOAD, a 16-bit modulo-2^16 sum of accepted words is accumulated.
  - VERIFY runs for `length` cycles with WE_tb = 0 and Addr_tb stepping base, base+1, …, wrapping mod 256.
  - MemOut is sampled at the end of each cycle into a second sum.
  - On exit, sums differ → error = 1. Then DONE.
  - Adds `length` cycles to the load. Skipped when no words were written.
- Disabled:
  - No VERIFY state and no sum registers; FLUSH goes directly to DONE.
  - error is set only for length > 256.

Test Plan:
- Basic load: start, base=0x10, length=4, stream 0xA001..0xA004 valid every cycle → four consecutive WE_tb cycles at Addr_tb 0x10..0x13 with matching data; done 2 cycles after the last write begins; processor readback of 0x12 = 0xA003.
- Wrap and backpressure: base=0xFE, length=3, in_valid toggling 1,0,1,0,1 → writes at 0xFE, 0xFF, 0x00 only on accepted cycles; WE_tb low in gap cycles.
- Boundaries:
  - length=0 → done in the 2nd cycle after start, no WE_tb, error=0.
  - length=300 → done with error=1 and no writes.
  - length=256, base=0x80 → 256 writes covering every address once.
- Reset mid-load: rst asserted after 2 of 8 words → Tbornot=0, WE_tb=0, busy=0 at the next edge; a subsequent start/load completes normally.
- Start while busy: a second start during LOAD → ignored; the latched base and length are unchanged.
- VERIFY (macro on):
  - Clean load of 8 words → error=0.
  - Bench model corrupts one memory word during FLUSH → error=1 at done, cleared by the next start.
